// File: rtl/game_pkg.sv
// Shared definitions for the game-over sequencer: FSM states, screen geometry
// and RGB332 field widths.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DROP         = 2'd1,
        HOLD         = 2'd2,
        WAIT_RESTART = 2'd3
    } state_t;

    localparam int H_RES      = 640;
    localparam int V_RES      = 480;
    localparam int FRAME_LINE = 480;

    localparam int RED_W   = 3;
    localparam int GREEN_W = 3;
    localparam int BLUE_W  = 2;
    localparam int RGB_W   = RED_W + GREEN_W + BLUE_W;

endpackage

// File: rtl/gameover_sequencer_if.sv
// Control and pixel link between the sequencer (master) and the 32x32 sprite
// renderer (slave).
interface gameover_sequencer_if;
    import game_pkg::*;

    logic                 spr_enable;
    logic [9:0]           spr_posx;
    logic [9:0]           spr_posy;
    logic                 spr_data;
    logic [RED_W-1:0]     spr_red;
    logic [GREEN_W-1:0]   spr_green;
    logic [BLUE_W-1:0]    spr_blue;

    modport master (
        output spr_enable, spr_posx, spr_posy,
        input  spr_data, spr_red, spr_green, spr_blue
    );

    modport slave (
        input  spr_enable, spr_posx, spr_posy,
        output spr_data, spr_red, spr_green, spr_blue
    );

endinterface

// File: rtl/gameover_sequencer_frame_tick.sv
// Once-per-frame pulse: registered rising edge of the (vcount == FRAME_LINE,
// hcount == 0) condition, so a stalled hcount still yields a single pulse.
module frame_tick
    import game_pkg::*;
#(
    parameter int FRAME_LINE = game_pkg::FRAME_LINE
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    output logic       tick
);

    logic cond_p0;
    logic cond_p1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cond_p0 <= 1'b0;
            cond_p1 <= 1'b0;
        end else begin
            cond_p0 <= (vcount == 10'(FRAME_LINE)) && (hcount == 10'd0);
            cond_p1 <= cond_p0;
        end
    end

    assign tick = cond_p0 && !cond_p1;

endmodule

// File: rtl/gameover_sequencer.sv
// Game-over sprite sequencer: IDLE -> DROP -> HOLD -> WAIT_RESTART, plus the
// registered sprite-over-background compositor. Optional HOLD blink: GAMEOVER_BLINK_EN.
module gameover_sequencer
    import game_pkg::*;
#(
    parameter int POS_X        = 304,
    parameter int START_Y      = 0,
    parameter int TARGET_Y     = 224,
    parameter int DROP_STEP    = 4,
    parameter int HOLD_FRAMES  = 180,
    parameter int BLINK_FRAMES = 15,
    parameter int FRAME_LINE   = game_pkg::FRAME_LINE
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 game_over,
    input  logic                 restart,
    input  logic [9:0]           hcount,
    input  logic [9:0]           vcount,
    gameover_sequencer_if.master spr,
    input  logic [RED_W-1:0]     bg_red,
    input  logic [GREEN_W-1:0]   bg_green,
    input  logic [BLUE_W-1:0]    bg_blue,
    output logic [RED_W-1:0]     red,
    output logic [GREEN_W-1:0]   green,
    output logic [BLUE_W-1:0]    blue,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_MAX = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state, state_n;
    logic [9:0]       posy, posy_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             tick;
    logic [10:0]      drop_sum;
    logic [10:0]      drop_next;
    logic             phase_vis;
    logic             vis;
    logic             vis_d;

    frame_tick #(.FRAME_LINE(FRAME_LINE)) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .hcount  (hcount),
        .vcount  (vcount),
        .tick    (tick)
    );

    // 11-bit step so a large DROP_STEP near the bottom cannot wrap past TARGET_Y
    assign drop_sum  = {1'b0, posy} + 11'(DROP_STEP);
    assign drop_next = (drop_sum > 11'(TARGET_Y)) ? 11'(TARGET_Y) : drop_sum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            posy  <= 10'(START_Y);
            cnt   <= '0;
        end else begin
            state <= state_n;
            posy  <= posy_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        posy_n  = posy;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (game_over) begin
                    state_n = DROP;
                    posy_n  = 10'(START_Y);
                    cnt_n   = '0;
                end
            end
            DROP: begin
                if (restart) begin
                    state_n = IDLE;
                end else if (tick) begin
                    posy_n = drop_next[9:0];
                    if (drop_next == 11'(TARGET_Y)) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                    end
                end
            end
            HOLD: begin
                posy_n = 10'(TARGET_Y);
                if (restart) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (cnt == CNT_W'(HOLD_FRAMES - 1)) state_n = WAIT_RESTART;
                    else                                cnt_n   = cnt + 1'b1;
                end
            end
            WAIT_RESTART: begin
                if (restart) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef GAMEOVER_BLINK_EN
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_on;

    // Phase restarts visible on every HOLD entry; only HOLD ticks advance it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (state != HOLD) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (tick && !restart) begin
            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign phase_vis = (state != HOLD) || blink_on;
`else
    assign phase_vis = 1'b1;
`endif

    assign spr.spr_enable = (state != IDLE);
    assign spr.spr_posx   = 10'(POS_X);
    assign spr.spr_posy   = posy;
    assign busy           = (state == DROP) || (state == HOLD);
    assign done           = (state == WAIT_RESTART);
    assign vis            = spr.spr_enable && phase_vis;

    // vis_d lines up with the sprite's registered spr_data; the sprite keeps
    // spr_data alive while disabled, so the gate is essential
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vis_d <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            vis_d <= vis;
            if (vis_d && spr.spr_data) begin
                red   <= spr.spr_red;
                green <= spr.spr_green;
                blue  <= spr.spr_blue;
            end else begin
                red   <= bg_red;
                green <= bg_green;
                blue  <= bg_blue;
            end
        end
    end

endmodule

// File: tb/tb_gameover_sequencer.sv
// Directed bench for gameover_sequencer (HOLD_FRAMES=4, BLINK_FRAMES=2);
// hold-phase pixel expectations follow GAMEOVER_BLINK_EN.
`timescale 1ns/1ps
module tb_gameover_sequencer;
    import game_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       game_over = 1'b0;
    logic       restart = 1'b0;
    logic [9:0] hcount = 10'd5;
    logic [9:0] vcount = 10'd0;
    logic [2:0] bg_red, bg_green, red, green;
    logic [1:0] bg_blue, blue;
    logic       busy, done;

    int checks = 0;
    int errors = 0;
    int tick_seen;

    gameover_sequencer_if spr_if ();

    gameover_sequencer #(
        .HOLD_FRAMES  (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .game_over (game_over),
        .restart   (restart),
        .hcount    (hcount),
        .vcount    (vcount),
        .spr       (spr_if.master),
        .bg_red    (bg_red),
        .bg_green  (bg_green),
        .bg_blue   (bg_blue),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One-clock frame line strobe; returns one clock after the FSM has acted on it
    task automatic frame;
        vcount = 10'd480;
        hcount = 10'd0;
        cycles(1);
        hcount = 10'd1;
        cycles(1);
    endtask

    task automatic pulse_game_over;
        game_over = 1'b1;
        cycles(1);
        game_over = 1'b0;
    endtask

    task automatic pulse_restart;
        restart = 1'b1;
        cycles(1);
        restart = 1'b0;
    endtask

    function automatic logic [7:0] rgb();
        return {red, green, blue};
    endfunction

    initial begin
        {bg_red, bg_green, bg_blue} = 8'h03;
        {spr_if.spr_red, spr_if.spr_green, spr_if.spr_blue} = 8'hE0;
        spr_if.spr_data = 1'b1;

        cycles(2);
        chk("rst_enable", 32'(spr_if.spr_enable), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_rgb",    32'(rgb()), 32'h00);
        chk("rst_posy",   32'(spr_if.spr_posy), 32'd0);

        reset_n = 1'b1;
        cycles(3);
        chk("idle_rgb_masked", 32'(rgb()), 32'h03);
        chk("posx", 32'(spr_if.spr_posx), 32'd304);

        pulse_game_over();
        chk("go_enable", 32'(spr_if.spr_enable), 32'd1);
        chk("go_posy",   32'(spr_if.spr_posy), 32'd0);
        chk("go_busy",   32'(busy), 32'd1);
        cycles(2);
        chk("drop_rgb_sprite", 32'(rgb()), 32'hE0);

        for (int i = 1; i <= 55; i++) begin
            frame();
            if (i == 1) chk("drop_posy_1", 32'(spr_if.spr_posy), 32'd4);
            if (busy !== 1'b1) chk("drop_busy", 32'(busy), 32'd1);
        end
        chk("drop_posy_55", 32'(spr_if.spr_posy), 32'd220);
        chk("drop_state_55", 32'(dut.state), 32'(DROP));
        frame();
        chk("drop_posy_56", 32'(spr_if.spr_posy), 32'd224);
        chk("hold_state", 32'(dut.state), 32'(HOLD));
        chk("hold_busy", 32'(busy), 32'd1);
        cycles(2);
        chk("hold_t0_rgb", 32'(rgb()), 32'hE0);

        frame();
        cycles(2);
        chk("hold_t1_rgb", 32'(rgb()), 32'hE0);
        frame();
        cycles(2);
`ifdef GAMEOVER_BLINK_EN
        chk("hold_t2_rgb", 32'(rgb()), 32'h03);
`else
        chk("hold_t2_rgb", 32'(rgb()), 32'hE0);
`endif
        chk("hold_t2_enable", 32'(spr_if.spr_enable), 32'd1);
        frame();
        chk("hold_t3_busy", 32'(busy), 32'd1);
        chk("hold_t3_done", 32'(done), 32'd0);
        cycles(2);
`ifdef GAMEOVER_BLINK_EN
        chk("hold_t3_rgb", 32'(rgb()), 32'h03);
`else
        chk("hold_t3_rgb", 32'(rgb()), 32'hE0);
`endif
        frame();
        chk("wait_done", 32'(done), 32'd1);
        chk("wait_busy", 32'(busy), 32'd0);
        cycles(2);
        chk("wait_rgb", 32'(rgb()), 32'hE0);

        pulse_game_over();
        chk("wait_ignores_go", 32'(dut.state), 32'(WAIT_RESTART));
        pulse_restart();
        chk("restart_idle", 32'(dut.state), 32'(IDLE));
        chk("restart_enable", 32'(spr_if.spr_enable), 32'd0);
        chk("restart_done", 32'(done), 32'd0);
        cycles(3);
        chk("idle_rgb_again", 32'(rgb()), 32'h03);

        // Restart on the same clock the FSM sees a tick
        pulse_game_over();
        frame();
        frame();
        chk("pre_race_posy", 32'(spr_if.spr_posy), 32'd8);
        vcount = 10'd480;
        hcount = 10'd0;
        cycles(1);
        hcount = 10'd1;
        restart = 1'b1;
        cycles(1);
        restart = 1'b0;
        chk("race_state", 32'(dut.state), 32'(IDLE));
        chk("race_enable", 32'(spr_if.spr_enable), 32'd0);
        chk("race_posy", 32'(spr_if.spr_posy), 32'd8);

        // hcount parked at 0 on the frame line for four clocks
        pulse_game_over();
        tick_seen = 0;
        vcount = 10'd480;
        hcount = 10'd0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) hcount = 10'd1;
            @(negedge clock);
            if (dut.tick === 1'b1) tick_seen++;
            @(posedge clock);
            #1;
        end
        chk("stall_tick_count", 32'(tick_seen), 32'd1);
        chk("stall_posy", 32'(spr_if.spr_posy), 32'd4);

        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_enable", 32'(spr_if.spr_enable), 32'd0);
        chk("async_rst_busy",   32'(busy), 32'd0);
        chk("async_rst_rgb",    32'(rgb()), 32'h00);
        chk("async_rst_posy",   32'(spr_if.spr_posy), 32'd0);
        chk("async_rst_vis_d",  32'(dut.vis_d), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
